// File: rtl/datapath_run_monitor_if.sv
// Bus between the SAD datapath side and its run monitor.
// master drives observations, slave (the monitor) drives verdicts.
interface datapath_run_monitor_if #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_RES = 2,
  parameter int CNT_W   = 32
) ();
  logic                      Enable;
  logic [PC_W-1:0]           PC;
  logic [NUM_RES*DATA_W-1:0] ResIn;
  logic [NUM_RES*DATA_W-1:0] ResExp;
  logic [DATA_W-1:0]         SadIn;
  logic                      Done;
  logic                      Pass;
  logic                      TimedOut;
  logic [NUM_RES-1:0]        MismatchMask;
  logic [NUM_RES*DATA_W-1:0] ResCap;
  logic [CNT_W-1:0]          CycleCount;
  logic [DATA_W-1:0]         MinSad;
  logic [CNT_W-1:0]          SadUpdates;

  modport master (
    output Enable, PC, ResIn, ResExp, SadIn,
    input  Done, Pass, TimedOut, MismatchMask,
    input  ResCap, CycleCount, MinSad, SadUpdates
  );

  modport slave (
    input  Enable, PC, ResIn, ResExp, SadIn,
    output Done, Pass, TimedOut, MismatchMask,
    output ResCap, CycleCount, MinSad, SadUpdates
  );
endinterface

// File: rtl/datapath_run_monitor.sv
// Run monitor for the pipelined SAD datapath: halt detection,
// result capture/compare, running min-SAD and cycle timeout.
module datapath_run_monitor #(
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_RES     = 2,
  parameter int HALT_CYCLES = 4,
  parameter int TIMEOUT     = 100000,
  parameter int CNT_W       = 32
) (
  input logic Clk,
  input logic Rst,
  datapath_run_monitor_if.slave bus
);

  localparam int SC_W =
    (HALT_CYCLES < 2) ? 1 : $clog2(HALT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TO = CNT_W'(TIMEOUT);
  localparam logic [SC_W-1:0] C_HLAST = SC_W'(HALT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t                    r_state;
  logic [PC_W-1:0]           r_pc_q;
  logic [SC_W-1:0]           r_stable;
  logic [CNT_W-1:0]          r_cyc;
  logic [CNT_W-1:0]          r_upd;
  logic [DATA_W-1:0]         r_min;
  logic                      r_done;
  logic                      r_pass;
  logic                      r_to;
  logic [NUM_RES-1:0]        r_mask;
  logic [NUM_RES*DATA_W-1:0] r_cap;

  logic                      w_run;
  logic                      w_same;
  logic                      w_halt;
  logic                      w_tmo;
  logic                      w_sad_lt;
  logic [SC_W-1:0]           w_stable_nx;
  logic [CNT_W-1:0]          w_cyc_nx;
  logic [CNT_W-1:0]          w_upd_nx;
  logic [NUM_RES-1:0]        w_mis;

  assign w_run    = (r_state == S_RUN) && bus.Enable;
  assign w_same   = (bus.PC == r_pc_q);
  assign w_halt   = w_same && (r_stable == C_HLAST);
  assign w_sad_lt = (bus.SadIn < r_min);

  // Counters saturate rather than wrap
  assign w_stable_nx = (&r_stable) ? r_stable : r_stable + SC_W'(1);
  assign w_cyc_nx    = (&r_cyc) ? r_cyc : r_cyc + CNT_W'(1);
  assign w_upd_nx    = (&r_upd) ? r_upd : r_upd + CNT_W'(1);
  assign w_tmo       = (w_cyc_nx == C_TO);

  always_comb begin
    w_mis = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      w_mis[i] = bus.ResIn[i*DATA_W +: DATA_W] !=
                 bus.ResExp[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= S_RUN;
      r_pc_q   <= '0;
      r_stable <= '0;
      r_cyc    <= '0;
      r_upd    <= '0;
      r_min    <= '1;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_to     <= 1'b0;
      r_mask   <= '0;
      r_cap    <= '0;
    end else if (w_run) begin
      r_pc_q   <= bus.PC;
      r_stable <= w_same ? w_stable_nx : '0;
      if (w_sad_lt) begin
        r_min <= bus.SadIn;
        r_upd <= w_upd_nx;
      end
      // Halt outranks a timeout landing on the same edge
      if (w_halt) begin
        r_state <= S_HALTED;
        r_cap   <= bus.ResIn;
        r_mask  <= w_mis;
        r_done  <= 1'b1;
        r_pass  <= ~|w_mis;
      end else begin
        r_cyc <= w_cyc_nx;
        if (w_tmo) begin
          r_state <= S_TIMEOUT;
          r_done  <= 1'b1;
          r_to    <= 1'b1;
          r_pass  <= 1'b0;
        end
      end
    end
  end

  assign bus.Done         = r_done;
  assign bus.Pass         = r_pass;
  assign bus.TimedOut     = r_to;
  assign bus.MismatchMask = r_mask;
  assign bus.ResCap       = r_cap;
  assign bus.CycleCount   = r_cyc;
  assign bus.MinSad       = r_min;
  assign bus.SadUpdates   = r_upd;

endmodule

// File: tb/tb_datapath_run_monitor.sv
// Bench for datapath_run_monitor: table-driven runs with a
// scoreboard queue, plus async-reset and timeout corner runs.
module tb_datapath_run_monitor;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  typedef struct {
    bit          en;
    logic [31:0] pc;
    logic [31:0] sad;
    bit          done;
    bit          pass;
    bit          to;
    logic [31:0] cyc;
    logic [31:0] mn;
    logic [31:0] upd;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t q[$];
  vec_t tbl[$];

  datapath_run_monitor_if #(
    .PC_W(32), .DATA_W(32), .NUM_RES(2), .CNT_W(32)
  ) bus ();

  datapath_run_monitor #(
    .PC_W(32), .DATA_W(32), .NUM_RES(2),
    .HALT_CYCLES(4), .TIMEOUT(50), .CNT_W(32)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(
    bit en, logic [31:0] pc, logic [31:0] sad,
    bit done, bit pass, bit to,
    logic [31:0] cyc, logic [31:0] mn, logic [31:0] upd
  );
    vec_t v;
    v.en = en; v.pc = pc; v.sad = sad;
    v.done = done; v.pass = pass; v.to = to;
    v.cyc = cyc; v.mn = mn; v.upd = upd;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(vec_t v);
    vec_t e;
    @(negedge Clk);
    bus.Enable = v.en;
    bus.PC     = v.pc;
    bus.SadIn  = v.sad;
    q.push_back(v);
    @(posedge Clk);
    #1;
    e = q.pop_front();
    chk("done", 64'(bus.Done), 64'(e.done));
    chk("pass", 64'(bus.Pass), 64'(e.pass));
    chk("timedout", 64'(bus.TimedOut), 64'(e.to));
    chk("cycles", 64'(bus.CycleCount), 64'(e.cyc));
    chk("minsad", 64'(bus.MinSad), 64'(e.mn));
    chk("sadupd", 64'(bus.SadUpdates), 64'(e.upd));
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  task automatic rst_pulse(string nm);
    Rst = 1'b1;
    #1;
    chk({nm, "_done"}, 64'(bus.Done), 64'd0);
    chk({nm, "_pass"}, 64'(bus.Pass), 64'd0);
    chk({nm, "_to"}, 64'(bus.TimedOut), 64'd0);
    chk({nm, "_mask"}, 64'(bus.MismatchMask), 64'd0);
    chk({nm, "_cap"}, bus.ResCap, 64'd0);
    chk({nm, "_cyc"}, 64'(bus.CycleCount), 64'd0);
    chk({nm, "_min"}, 64'(bus.MinSad), 64'(ALL1));
    chk({nm, "_upd"}, 64'(bus.SadUpdates), 64'd0);
    #1;
    Rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    bus.Enable = 1'b0;
    bus.PC     = '0;
    bus.SadIn  = ALL1;
    rst_pulse("reset");
  endtask

  task automatic fill_halt(bit p);
    tbl.push_back(mk(1, 32'h0, 40, 0, 0, 0, 1, 40, 1));
    tbl.push_back(mk(1, 32'h4, 25, 0, 0, 0, 2, 25, 2));
    tbl.push_back(mk(1, 32'h8, 25, 0, 0, 0, 3, 25, 2));
    tbl.push_back(mk(1, 32'hC, 30, 0, 0, 0, 4, 25, 2));
    tbl.push_back(mk(1, 32'h10, 12, 0, 0, 0, 5, 12, 3));
    tbl.push_back(mk(1, 32'h10, 12, 0, 0, 0, 6, 12, 3));
    tbl.push_back(mk(1, 32'h10, 12, 0, 0, 0, 7, 12, 3));
    tbl.push_back(mk(1, 32'h10, 12, 0, 0, 0, 8, 12, 3));
    tbl.push_back(mk(1, 32'h10, 12, 1, p, 0, 8, 12, 3));
    tbl.push_back(mk(1, 32'h14, 5, 1, p, 0, 8, 12, 3));
  endtask

  initial begin
    bus.Enable = 1'b0;
    bus.PC     = '0;
    bus.SadIn  = ALL1;
    bus.ResIn  = {32'd7, 32'd3};
    bus.ResExp = {32'd7, 32'd3};

    // Run 1: halt with matching results
    do_reset();
    fill_halt(1'b1);
    run_tbl();
    chk("r1_mask", 64'(bus.MismatchMask), 64'd0);
    chk("r1_cap", bus.ResCap, {32'd7, 32'd3});

    // Run 2: v1 expected 8 -> mismatch on channel 1
    do_reset();
    bus.ResExp = {32'd8, 32'd3};
    fill_halt(1'b0);
    run_tbl();
    chk("r2_mask", 64'(bus.MismatchMask), 64'b10);
    chk("r2_cap", bus.ResCap, {32'd7, 32'd3});

    // Async reset 3 ns after Done, away from any edge
    #2;
    rst_pulse("async");
    bus.ResExp = {32'd7, 32'd3};

    // Run 3: enable gap while PC is held
    do_reset();
    tbl.push_back(mk(1, 32'h20, ALL1, 0, 0, 0, 1, ALL1, 0));
    tbl.push_back(mk(1, 32'h20, ALL1, 0, 0, 0, 2, ALL1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 32'h20, 1, 0, 0, 0, 2, ALL1, 0));
    tbl.push_back(mk(1, 32'h20, ALL1, 0, 0, 0, 3, ALL1, 0));
    tbl.push_back(mk(1, 32'h20, ALL1, 0, 0, 0, 4, ALL1, 0));
    tbl.push_back(mk(1, 32'h20, ALL1, 1, 1, 0, 4, ALL1, 0));
    run_tbl();

    // Run 4: PC never settles -> timeout at 50, then frozen
    do_reset();
    for (int k = 1; k <= 53; k++) begin
      tbl.push_back(mk(1, 32'(k * 4), ALL1, k >= 50, 0,
                       k >= 50, (k >= 50) ? 50 : k, ALL1, 0));
    end
    run_tbl();
    chk("r4_mask", 64'(bus.MismatchMask), 64'd0);
    chk("r4_cap", bus.ResCap, 64'd0);

    // Run 5: halt lands on the timeout edge -> halt wins
    do_reset();
    for (int k = 1; k <= 46; k++)
      tbl.push_back(mk(1, 32'(k * 4), ALL1, 0, 0, 0, k, ALL1, 0));
    for (int k = 47; k <= 49; k++)
      tbl.push_back(mk(1, 32'd184, ALL1, 0, 0, 0, k, ALL1, 0));
    tbl.push_back(mk(1, 32'd184, ALL1, 1, 1, 0, 49, ALL1, 0));
    tbl.push_back(mk(1, 32'd188, ALL1, 1, 1, 0, 49, ALL1, 0));
    run_tbl();
    chk("r5_cap", bus.ResCap, {32'd7, 32'd3});

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
